// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the data-cache refill path: the refill FSM state
// encoding, the line geometry (words per line, offset width) and the default
// data/address widths used as parameter defaults by the refill blocks.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

   // Line geometry: one line is four one-byte words.
   localparam int CACHE_WORDS  = 4;
   localparam int CACHE_OFF_W  = 2;

   // Default widths of the cache data path.
   localparam int CACHE_DATA_W = 8;
   localparam int CACHE_ADDR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WRITE = 2'd2
   } refill_state_e;

endpackage : cache_pkg

// File: rtl/refill_word_counter.sv
// -----------------------------------------------------------------------------
// refill_word_counter
// Word sequencing for one line refill. Holds the start offset and the count
// of words already returned; the current offset is their modulo-4 sum, so a
// fill starting at any offset wraps naturally (e.g. 2,3,0,1).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_start         load i_start_off and clear the word count
//   i_start_off     first offset of the new fill
//   i_advance       one word accepted (memory ack in FETCH)
//   o_cur_off       offset of the word currently requested
//   o_first_word    no word of this fill has been returned yet
//   o_last_word     the word being requested is the fourth of the fill
// -----------------------------------------------------------------------------
module refill_word_counter
   import cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic [CACHE_OFF_W-1:0] i_start_off,
   input  logic                   i_advance,
   output logic [CACHE_OFF_W-1:0] o_cur_off,
   output logic                   o_first_word,
   output logic                   o_last_word
);

   logic [CACHE_OFF_W-1:0] r_start_off;
   logic [CACHE_OFF_W-1:0] r_count;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_off <= '0;
         r_count     <= '0;
      end else if (i_start) begin
         r_start_off <= i_start_off;
         r_count     <= '0;
      end else if (i_advance) begin
         // Wraps back to 0 after the fourth word, ready for the next fill.
         r_count <= r_count + CACHE_OFF_W'(1);
      end
   end

   // Two-bit add wraps 3 -> 0 without any explicit modulo logic.
   assign o_cur_off    = r_start_off + r_count;
   assign o_first_word = (r_count == '0);
   assign o_last_word  = (r_count == CACHE_OFF_W'(CACHE_WORDS - 1));

endmodule : refill_word_counter

// File: rtl/cache_line_refill.sv
// -----------------------------------------------------------------------------
// cache_line_refill
// Miss-refill engine for the direct-mapped data cache. On a miss it reads the
// four bytes of the missing block one word at a time, assembles them in line
// registers and pulses a one-cycle write into the data array.
//
// Optional feature macro: CACHE_CRIT_WORD_FIRST_EN
//   defined   - fetch starts at the missed byte offset and wraps; an extra
//               output crit_valid pulses the cycle after the first ack.
//   undefined - fetch always runs offsets 0,1,2,3; no crit_valid port.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   miss_req, miss_addr       miss request and byte address (sampled in IDLE)
//   busy                      refill in progress (FETCH and WRITE)
//   mem_read, mem_addr        memory read request and word byte address
//   mem_ack, mem_rdata        memory data return
//   line_data0x..line_data3x  assembled line, byte offsets 0..3
//   line_addr                 block address of the line being written
//   line_write, refill_done   one-cycle data-array write / completion pulse
//   crit_valid                critical word available (feature builds only)
// -----------------------------------------------------------------------------
module cache_line_refill
   import cache_pkg::*;
#(
   parameter int DATA_W = CACHE_DATA_W,
   parameter int ADDR_W = CACHE_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   output logic              busy,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] line_data0x,
   output logic [DATA_W-1:0] line_data1x,
   output logic [DATA_W-1:0] line_data2x,
   output logic [DATA_W-1:0] line_data3x,
   output logic [ADDR_W-3:0] line_addr,
   output logic              line_write,
   output logic              refill_done
`ifdef CACHE_CRIT_WORD_FIRST_EN
   ,
   output logic              crit_valid
`endif
);

   refill_state_e          r_state;
   refill_state_e          w_next_state;
   logic [ADDR_W-3:0]      r_line_addr;
   logic [DATA_W-1:0]      r_line [CACHE_WORDS];
   logic                   w_start;
   logic                   w_ack;
   logic                   w_first_word;
   logic                   w_last_word;
   logic [CACHE_OFF_W-1:0] w_start_off;
   logic [CACHE_OFF_W-1:0] w_cur_off;

   // Acceptance only in IDLE; acks outside FETCH are ignored.
   assign w_start = (r_state == ST_IDLE) && miss_req;
   assign w_ack   = (r_state == ST_FETCH) && mem_ack;

`ifdef CACHE_CRIT_WORD_FIRST_EN
   assign w_start_off = miss_addr[CACHE_OFF_W-1:0];
`else
   assign w_start_off = '0;
   // The byte offset and first-word flag only matter to critical-word-first.
   logic w_unused;
   assign w_unused = ^{miss_addr[CACHE_OFF_W-1:0], w_first_word};
`endif

   refill_word_counter u_word_counter (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (w_start),
      .i_start_off  (w_start_off),
      .i_advance    (w_ack),
      .o_cur_off    (w_cur_off),
      .o_first_word (w_first_word),
      .o_last_word  (w_last_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      mem_read     = 1'b0;
      line_write   = 1'b0;
      refill_done  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (miss_req) w_next_state = ST_FETCH;
         end
         ST_FETCH: begin
            busy     = 1'b1;
            mem_read = 1'b1;
            if (mem_ack && w_last_word) w_next_state = ST_WRITE;
         end
         ST_WRITE: begin
            busy         = 1'b1;
            line_write   = 1'b1;
            refill_done  = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: the line registers drive the byte-select mux directly and must read
   // as zero after reset, so they are flops with reset rather than a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_addr <= '0;
         for (int i = 0; i < CACHE_WORDS; i++) r_line[i] <= '0;
      end else begin
         if (w_start) r_line_addr <= miss_addr[ADDR_W-1:CACHE_OFF_W];
         // Unfetched bytes keep their stale contents until overwritten.
         if (w_ack)   r_line[w_cur_off] <= mem_rdata;
      end
   end

`ifdef CACHE_CRIT_WORD_FIRST_EN
   logic r_crit_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_crit_valid <= 1'b0;
      else        r_crit_valid <= w_ack && w_first_word;
   end

   assign crit_valid = r_crit_valid;
`endif

   assign mem_addr    = {r_line_addr, w_cur_off};
   assign line_addr   = r_line_addr;
   assign line_data0x = r_line[0];
   assign line_data1x = r_line[1];
   assign line_data2x = r_line[2];
   assign line_data3x = r_line[3];

endmodule : cache_line_refill

// File: tb/tb_cache_line_refill.sv
// -----------------------------------------------------------------------------
// tb_cache_line_refill
// Self-checking bench for cache_line_refill. Expected word addresses and final
// line contents are queued when a miss is issued and popped as the DUT
// requests words and writes the line. A shadow copy of the line registers
// tracks stale bytes across fills and reset. Inputs change and outputs are
// sampled on the falling clock edge. Works with or without
// CACHE_CRIT_WORD_FIRST_EN.
// -----------------------------------------------------------------------------
module tb_cache_line_refill;
   import cache_pkg::*;

   localparam int DW = 8;
   localparam int AW = 8;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          miss_req  = 1'b0;
   logic [AW-1:0] miss_addr = '0;
   logic          mem_ack   = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy, mem_read, line_write, refill_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] line_data0x, line_data1x, line_data2x, line_data3x;
   logic [AW-3:0] line_addr;
`ifdef CACHE_CRIT_WORD_FIRST_EN
   logic          crit_valid;
`endif

   cache_line_refill #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .miss_req    (miss_req),
      .miss_addr   (miss_addr),
      .busy        (busy),
      .mem_read    (mem_read),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .line_data0x (line_data0x),
      .line_data1x (line_data1x),
      .line_data2x (line_data2x),
      .line_data3x (line_data3x),
      .line_addr   (line_addr),
      .line_write  (line_write),
      .refill_done (refill_done)
`ifdef CACHE_CRIT_WORD_FIRST_EN
      ,
      .crit_valid  (crit_valid)
`endif
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            n_writes = 0;
   logic [AW-1:0] q_addr [$];
   logic [31:0]   q_line [$];
   logic [DW-1:0] m_line [4];

   // Counts every write strobe, so stray or missing writes show up at the end.
   always @(negedge clk) if (line_write === 1'b1) n_writes++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_line(input string tag);
      check({tag, "_b0"}, 32'(line_data0x), 32'(m_line[0]));
      check({tag, "_b1"}, 32'(line_data1x), 32'(m_line[1]));
      check({tag, "_b2"}, 32'(line_data2x), 32'(m_line[2]));
      check({tag, "_b3"}, 32'(line_data3x), 32'(m_line[3]));
   endtask

   // Issues a miss at a falling edge and serves it with 'waits' idle cycles
   // before each ack. Memory returns base + byte offset for each word. Ends on
   // the falling edge of the first cycle after WRITE.
   task automatic do_fill(input logic [AW-1:0] addr, input int waits,
                          input logic [DW-1:0] base, input bit hold);
      logic [1:0]    off0;
      logic [AW-1:0] a;
      logic [31:0]   exp_line;
`ifdef CACHE_CRIT_WORD_FIRST_EN
      off0 = addr[1:0];
`else
      off0 = 2'd0;
`endif
      for (int i = 0; i < 4; i++) q_addr.push_back({addr[AW-1:2], 2'(off0 + 2'(i))});
      q_line.push_back({base + 8'd3, base + 8'd2, base + 8'd1, base});
      miss_req  = 1'b1;
      miss_addr = addr;
      @(negedge clk);
      if (!hold) miss_req = 1'b0;
      check("busy_fetch", 32'(busy), 32'd1);
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < waits; k++) begin
            check("mem_read_wait", 32'(mem_read), 32'd1);
            @(negedge clk);
         end
         a = q_addr.pop_front();
         check("mem_read", 32'(mem_read), 32'd1);
         check("mem_addr", 32'(mem_addr), 32'(a));
         check("no_early_write", 32'(line_write), 32'd0);
         mem_ack   = 1'b1;
         mem_rdata = base + DW'(a[1:0]);
         m_line[a[1:0]] = mem_rdata;
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = '0;
         check_line("line_after_ack");
`ifdef CACHE_CRIT_WORD_FIRST_EN
         check("crit_valid", 32'(crit_valid), 32'(w == 0));
`endif
      end
      // WRITE cycle
      check("line_write", 32'(line_write), 32'd1);
      check("refill_done", 32'(refill_done), 32'd1);
      check("busy_write", 32'(busy), 32'd1);
      check("mem_read_write", 32'(mem_read), 32'd0);
      check("line_addr", 32'(line_addr), 32'(addr[AW-1:2]));
      exp_line = q_line.pop_front();
      check("line_final", {line_data3x, line_data2x, line_data1x, line_data0x}, exp_line);
      @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      check("line_write_idle", 32'(line_write), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
      check({tag, "_line_write"}, 32'(line_write), 32'd0);
      check({tag, "_refill_done"}, 32'(refill_done), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_line_addr"}, 32'(line_addr), 32'd0);
      check({tag, "_line"}, {line_data3x, line_data2x, line_data1x, line_data0x}, 32'd0);
`ifdef CACHE_CRIT_WORD_FIRST_EN
      check({tag, "_crit_valid"}, 32'(crit_valid), 32'd0);
`endif
   endtask

   initial begin
      m_line = '{default: '0};
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic fill, zero-wait memory.
      do_fill(8'h5A, 0, 8'h10, 1'b0);
      // Three wait cycles per word: mem_read must stay high throughout.
      do_fill(8'h3D, 3, 8'h20, 1'b0);
      // miss_req held through the fill: no re-accept in WRITE, new fill
      // accepted in the first IDLE cycle.
      do_fill(8'hA1, 0, 8'h30, 1'b1);
      do_fill(8'hA1, 0, 8'h38, 1'b0);

      // Reset after the second ack of a fill aborts it with no write.
      miss_req  = 1'b1;
      miss_addr = 8'h9C;
      @(negedge clk);
      miss_req = 1'b0;
      for (int w = 0; w < 2; w++) begin
         mem_ack   = 1'b1;
         mem_rdata = 8'h40 + 8'(w);
         @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset_mid");
      @(negedge clk);
      check_all_zero("reset_hold");
      rst_n  = 1'b1;
      m_line = '{default: '0};
      // Fresh fill: unfetched bytes read as cleared, never the aborted data.
      do_fill(8'h04, 0, 8'h70, 1'b0);

      // Spurious acks in IDLE are ignored.
      mem_ack   = 1'b1;
      mem_rdata = 8'hFF;
      repeat (2) begin
         @(negedge clk);
         check("spur_busy", 32'(busy), 32'd0);
         check("spur_mem_read", 32'(mem_read), 32'd0);
         check("spur_line_write", 32'(line_write), 32'd0);
         check_line("spur_line");
      end
      mem_ack   = 1'b0;
      mem_rdata = '0;

      repeat (3) @(negedge clk);
      check("total_writes", 32'(n_writes), 32'd5);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_cache_line_refill
